// File: rtl/mem_request_initiator.sv
// rtl/mem_request_initiator.sv - CPU-side load/store initiator for the word-addressed RAM controller
`timescale 1ns/1ps

module mem_request_initiator #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 9,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clock,
    input  logic                     clear_n,
    input  logic                     req_read,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     req_busy,
    output logic                     req_done,
    output logic                     req_error,
    output logic [DATA_WIDTH-1:0]    mdr_out,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_out,
    input  logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic                     mem_complete
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    // Leaving a wait state when the count reaches TIMEOUT_CYCLES-1 means deciding one cycle earlier.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_CLR,
        S_WAIT_DONE,
        S_RESP,
        S_ERR
    } state_t;

    state_t                   state_q, state_d;
    logic                     sync_meta_q, sync_meta_d;
    logic                     cs_q, cs_d;
    logic                     op_write_q, op_write_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]    mem_data_out_q, mem_data_out_d;
    logic [DATA_WIDTH-1:0]    mdr_q, mdr_d;
    logic                     mem_read_q, mem_read_d;
    logic                     mem_write_q, mem_write_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     timed_out;
    logic                     strobe_on;
    logic [CNT_W-1:0]         count_inc;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q        <= S_IDLE;
            sync_meta_q    <= 1'b0;
            cs_q           <= 1'b0;
            op_write_q     <= 1'b0;
            count_q        <= '0;
            mem_address_q  <= '0;
            mem_data_out_q <= '0;
            mdr_q          <= '0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_meta_q    <= sync_meta_d;
            cs_q           <= cs_d;
            op_write_q     <= op_write_d;
            count_q        <= count_d;
            mem_address_q  <= mem_address_d;
            mem_data_out_q <= mem_data_out_d;
            mdr_q          <= mdr_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    always_comb begin
        sync_meta_d    = mem_complete;
        cs_d           = sync_meta_q;
        state_d        = state_q;
        op_write_d     = op_write_q;
        count_d        = count_q;
        mem_address_d  = mem_address_q;
        mem_data_out_d = mem_data_out_q;
        mdr_d          = mdr_q;
        timed_out      = (count_q >= CNT_LIMIT);
        count_inc      = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (req_read || req_write) begin
                    op_write_d     = req_write;
                    mem_address_d  = req_address;
                    mem_data_out_d = req_wdata;
                    count_d        = '0;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                count_d = count_inc;
                // A complete still high here belongs to the previous access.
                if (timed_out) begin
                    state_d = S_ERR;
                end else if (!cs_q) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                count_d = count_inc;
                if (timed_out) begin
                    state_d = S_ERR;
                end else if (cs_q) begin
                    state_d = S_RESP;
                    if (!op_write_q) begin
                        mdr_d = mem_data_in;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            mem_address_d  = '0;
            mem_data_out_d = '0;
        end

        strobe_on   = (state_d == S_ISSUE) || (state_d == S_WAIT_CLR) || (state_d == S_WAIT_DONE);
        mem_read_d  = strobe_on && !op_write_d;
        mem_write_d = strobe_on && op_write_d;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_RESP) || (state_d == S_ERR);
        error_d     = (state_d == S_ERR);
    end

    assign req_busy     = busy_q;
    assign req_done     = done_q;
    assign req_error    = error_q;
    assign mdr_out      = mdr_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_address  = mem_address_q;
    assign mem_data_out = mem_data_out_q;

endmodule

// File: tb/tb_mem_request_initiator.sv
// tb/tb_mem_request_initiator.sv - directed self-checking bench for mem_request_initiator
`timescale 1ns/1ps

module tb_mem_request_initiator;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        req_read, req_write;
    logic [8:0]  req_address;
    logic [31:0] req_wdata;
    logic        req_busy, req_done, req_error;
    logic [31:0] mdr_out;
    logic        mem_read, mem_write;
    logic [8:0]  mem_address;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    logic        mem_complete;

    logic        to_req_read, to_req_write, to_complete;
    logic        to_busy, to_done, to_error;
    logic [31:0] to_mdr;
    logic        to_mem_read, to_mem_write;
    logic [8:0]  to_mem_address;
    logic [31:0] to_mem_data_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    mem_request_initiator #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .clear_n(clear_n),
        .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_busy(req_busy), .req_done(req_done), .req_error(req_error),
        .mdr_out(mdr_out),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in), .mem_complete(mem_complete)
    );

    // Controller that never clears complete, for the timeout case.
    mem_request_initiator #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .TIMEOUT_CYCLES(8)) dut_to (
        .clock(clock), .clear_n(clear_n),
        .req_read(to_req_read), .req_write(to_req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_busy(to_busy), .req_done(to_done), .req_error(to_error),
        .mdr_out(to_mdr),
        .mem_read(to_mem_read), .mem_write(to_mem_write),
        .mem_address(to_mem_address), .mem_data_out(to_mem_data_out),
        .mem_data_in(mem_data_in), .mem_complete(to_complete)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [8:0] addr, input logic [31:0] wd,
                           input int clr_at, input int set_at, input logic [31:0] rdata,
                           input int busy_req_at, input logic exp_write,
                           input int exp_done_c, input logic [31:0] exp_mdr);
        int done_c   = -1;
        int done_cnt = 0;
        bit strobe_bad = 0, hold_bad = 0, busy_bad = 0;
        @(negedge clock);
        req_read = rd; req_write = wr; req_address = addr; req_wdata = wd;
        @(posedge clock);
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (req_done) begin
                done_cnt++;
                if (done_c < 0) begin
                    done_c = c;
                    check({name, "_strobe_drop"}, {mem_read, mem_write}, 2'b00);
                    check({name, "_error"}, req_error, 1'b0);
                    check({name, "_addr_at_done"}, mem_address, addr);
                    check({name, "_mdr"}, mdr_out, exp_mdr);
                end
            end else if (done_c < 0) begin
                if (mem_write !== exp_write || mem_read !== ~exp_write) strobe_bad = 1;
                if (mem_address !== addr || mem_data_out !== wd) hold_bad = 1;
                if (req_busy !== 1'b1) busy_bad = 1;
            end
            if (done_c >= 0 && c == done_c + 1) begin
                check({name, "_idle_busy"}, req_busy, 1'b0);
                check({name, "_idle_addr"}, mem_address, 9'h0);
            end
            if (c == 0) begin
                req_read = 0; req_write = 0; req_address = 9'h0AA; req_wdata = 32'h0;
            end
            if (c == busy_req_at) req_read = 1;
            else if (c == busy_req_at + 1) req_read = 0;
            if (c == clr_at) mem_complete = 1'b0;
            if (c == set_at) begin
                mem_complete = 1'b1;
                mem_data_in  = rdata;
            end
            if (done_c >= 0 && c == done_c + 3) break;
        end
        req_read = 0;
        check({name, "_done_cycle"}, done_c, exp_done_c);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_strobe_held"}, strobe_bad, 1'b0);
        check({name, "_addr_data_held"}, hold_bad, 1'b0);
        check({name, "_busy_held"}, busy_bad, 1'b0);
    endtask

    initial begin
        int to_done_c;
        int to_done_cnt;
        logic to_strobe_before;
        clear_n = 0; req_read = 0; req_write = 0; req_address = 0; req_wdata = 0;
        mem_data_in = 0; mem_complete = 1'b1;
        to_req_read = 0; to_req_write = 0; to_complete = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", {req_busy, req_done, req_error, mem_read, mem_write}, 5'b0);
        check("reset_addr_data", {mem_address, mem_data_out}, 41'h0);
        check("reset_mdr", mdr_out, 32'h0);
        clear_n = 1;
        repeat (3) @(posedge clock);

        run_txn("read",  1, 0, 9'h005, 32'h0,        1, 4, 32'hDEADBEEF, -1, 0, 7,  32'hDEADBEEF);
        run_txn("write", 0, 1, 9'h1FF, 32'h12345678, 1, 4, 32'hBADC0FFE, -1, 1, 7,  32'hDEADBEEF);
        run_txn("stale", 1, 0, 9'h0A3, 32'h0,        5, 8, 32'h0BADF00D, -1, 0, 11, 32'h0BADF00D);
        run_txn("collide", 1, 1, 9'h100, 32'hA5A5A5A5, 1, 4, 32'h11111111, 2, 1, 7, 32'h0BADF00D);

        // Reset while waiting for completion.
        @(negedge clock);
        req_read = 1; req_address = 9'h033;
        @(posedge clock);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (c == 0) req_read = 0;
            if (c == 1) mem_complete = 1'b0;
        end
        check("pre_reset_read", {req_busy, mem_read}, 2'b11);
        #2 clear_n = 0;
        #1;
        check("async_reset_strobe", mem_read, 1'b0);
        check("async_reset_busy", req_busy, 1'b0);
        check("async_reset_done", req_done, 1'b0);
        @(negedge clock);
        check("reset_hold_done", req_done, 1'b0);
        check("reset_hold_mdr", mdr_out, 32'h0);
        clear_n = 1;
        run_txn("after_reset", 1, 0, 9'h077, 32'h0, 1, 4, 32'hCAFEF00D, -1, 0, 7, 32'hCAFEF00D);

        // Timeout on the instance whose controller never clears complete.
        to_done_c = -1;
        to_done_cnt = 0;
        to_strobe_before = 0;
        @(negedge clock);
        to_req_read = 1;
        @(posedge clock);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (c == 0) to_req_read = 0;
            if (c == 7) to_strobe_before = to_mem_read;
            if (to_done) begin
                to_done_cnt++;
                if (to_done_c < 0) begin
                    to_done_c = c;
                    check("timeout_error", to_error, 1'b1);
                    check("timeout_strobe_drop", {to_mem_read, to_mem_write}, 2'b00);
                end
            end
            if (to_done_c >= 0 && c == to_done_c + 1) check("timeout_idle_busy", to_busy, 1'b0);
        end
        check("timeout_cycle", to_done_c, 8);
        check("timeout_done_count", to_done_cnt, 1);
        check("timeout_strobe_before", to_strobe_before, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_request_initiator.md
Name: mem_request_initiator

Overview:
- CPU-side initiator for the word-addressed RAM register-module controller.
- Accepts one load or store request from the control unit and drives the controller's read/write/address/data strobes.
- Waits for the controller's complete flag, then latches read data into an MDR-style register and returns a one-cycle done pulse.
- Bounded timeout guards against a controller that never completes.

Parameters:
DATA_WIDTH, 32, memory word width
ADDRESS_WIDTH, 9, word address width (512 words)
TIMEOUT_CYCLES, 64, max cycles spent in the WAIT_* states before error; must be >= 2

Ports:
clock  input  1  system clock, rising edge
clear_n  input  1  asynchronous active-low reset
req_read  input  1  load request, sampled in IDLE only
req_write  input  1  store request, sampled in IDLE only
req_address  input  ADDRESS_WIDTH  word address
req_wdata  input  DATA_WIDTH  store data
req_busy  output  1  high whenever state != IDLE
req_done  output  1  one-cycle pulse: transaction finished (success or error)
req_error  output  1  valid with req_done: timeout occurred
mdr_out  output  DATA_WIDTH  last successfully read word
mem_read  output  1  read strobe to controller
mem_write  output  1  write strobe to controller
mem_address  output  ADDRESS_WIDTH  address to controller
mem_data_out  output  DATA_WIDTH  write data to controller
mem_data_in  input  DATA_WIDTH  read data from controller
mem_complete  input  1  controller completion level; controller clears it on a new strobe/address

Behaviour:
- Reset (clear_n low, async): state=IDLE; all outputs 0; mdr_out=0; sync flops=0; timeout counter=0. Deassertion is taken synchronously on the next edge.
- mem_complete passes through a 2-flop synchronizer; all decisions use the synchronized value cs.
- Request latch (IDLE): req_read or req_write high -> latch op, address and wdata, go to ISSUE.
  - Both high: write wins, read is dropped.
  - Requests outside IDLE are ignored (no queue).
- States:
  - IDLE.
  - ISSUE (1 cycle): drive mem_address/mem_data_out from the latches; raise mem_read or mem_write. Next: WAIT_CLR.
  - WAIT_CLR: strobe held. cs==0 -> WAIT_DONE. This stage rejects a stale complete left over from the previous transaction.
  - WAIT_DONE: strobe held. cs==1 -> RESP.
  - RESP (1 cycle): drop strobe; req_done=1.
    - Read: mdr_out <= mem_data_in. Data is sampled at the RESP edge, so it is stable ≥2 cycles after complete.
    - Write: mdr_out unchanged.
    - Next: IDLE.
  - ERR (1 cycle): drop strobe; req_done=1, req_error=1; mdr_out unchanged. Next: IDLE.
- Timeout: counter clears on entry to ISSUE and increments each cycle in WAIT_CLR or WAIT_DONE.
  - Counter reaching TIMEOUT_CYCLES-1 while still waiting -> ERR. This takes priority over a same-cycle cs transition.
  - Counter saturates and never wraps.
- Latency: best case is req -> req_done in 5 cycles (IDLE sample, ISSUE, WAIT_CLR, WAIT_DONE, RESP), plus synchronizer delay of the controller's response.
- Output registration and timing:
  - mem_address and mem_data_out are registered and held constant from ISSUE through RESP; they are 0 in IDLE.
  - mem_read and mem_write are never high together.
  - req_busy is high from the cycle after request sampling through RESP/ERR.
  - req_done is back-to-back capable: a new request may be sampled in the IDLE cycle immediately after RESP.
- Reset mid-transaction: strobes drop asynchronously, state returns to IDLE, and no req_done is produced.

Test Plan:
- Read: req_read, addr 9'h005; controller model clears complete 1 cycle after mem_read, sets it 3 cycles later with data 32'hDEADBEEF -> mem_read held until RESP, one req_done pulse, req_error=0, mdr_out=32'hDEADBEEF.
- Write: req_write, addr 9'h1FF, wdata 32'h12345678 -> mem_write=1, mem_address=9'h1FF, mem_data_out=32'h12345678 stable until done; mdr_out retains its prior value.
- Stale complete: mem_complete left high from the previous access and cleared 4 cycles late -> FSM stays in WAIT_CLR and does not finish early; done only after the fresh rising level.
- Timeout: TIMEOUT_CYCLES=8, controller never clears complete -> req_done and req_error pulse exactly 8 cycles after ISSUE, strobes drop, then IDLE.
- Collisions: req_read and req_write both high -> a write is issued. A new req_read while busy is ignored, with exactly one req_done.
- Reset: clear_n pulled low during WAIT_DONE -> mem_read drops without a clock, no req_done, req_busy=0; the next read after release completes normally.
